instr_pair_fetch: RTL and testbench
===================================

# instr_pair_fetch

Dual-issue fetch front end that supplies the instruction-pair relayer. Requests aligned 32-bit instruction pairs from instruction memory, buffers them in a small circular queue, and presents two 16-bit instructions per cycle. Responds to the relayer's single-issue indication by delivering only one new instruction in the next cycle, so no instruction is lost or duplicated. Handles branch redirects, odd-aligned targets and halt.

## Interface
- `AW`, 8: instruction word address width (16-bit words).
- `DEPTH`, 4: queue depth in 16-bit words; power of two, ≥4.
- `RESET_PC`, 0: word address fetched after reset.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `single_i`  in  1  relayer issued only one instruction of the current pair.
- `redirect_valid_i`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc_i`  in  AW  redirect target word address.
- `imem_rd_en_o`  out  1  one-cycle read request.
- `imem_addr_o`  out  AW  pair-aligned word address (bit 0 = 0).
- `imem_rdata_i`  in  32  [15:0] = word at addr, [31:16] = word at addr+1.
- `imem_rvalid_i`  in  1  read data valid, ≥1 cycle after request.
- `instr1_o`  out  16  older instruction of the pair.
- `instr2_o`  out  16  younger instruction of the pair.
- `halted_o`  out  1  halt opcode fetched; fetch stopped.

## Operation
- NOP = 16'h0000; opcode = [15:12]; HALT opcode = 4'hF.
- Queue: circular, DEPTH words, rd/wr pointers wrap modulo DEPTH, occupancy count 0..DEPTH. Up to 2 pushes and 2 pops per cycle, same-cycle push and pop allowed.
- Issue, each cycle, registered into `instr1_o`/`instr2_o`:
  - count ≥ 2 and `single_i` = 0: q[0], q[1]; pop 2.
  - count ≥ 1 and (`single_i` = 1 or count = 1): q[0], NOP; pop 1.
  - count = 0: NOP, NOP.
- Fetch: at most one outstanding request. Request when no outstanding, not halted, no redirect this cycle, and (count − pops this cycle + 2) ≤ DEPTH. Address = pc with bit 0 cleared; pc += 2 on request.
- Response: push [15:0] then [31:16]. If the skip_low flag is set (odd redirect target), push only [31:16] and clear the flag.
- Halt: a pushed word with opcode 4'hF sets `halted_o`. Any following word in that response is discarded; no further requests are made. Queued words, including the HALT, still drain.
- Redirect: with priority over all else in that cycle, the queue empties, outputs become NOP/NOP at the next edge, pc = target, skip_low = target[0], `halted_o` clears. An in-flight response is marked stale and dropped on arrival; no new request is made until it returns.

## Timing
- Reset values: pc = RESET_PC, count = 0, pointers = 0, `instr1_o` = `instr2_o` = 16'h0, `imem_rd_en_o` = 0, `imem_addr_o` = 0, `halted_o` = 0, outstanding = 0, stale = 0, skip_low = 0.
- Reset asserted mid-operation returns everything to reset values immediately, asynchronously.
- Earliest `imem_rd_en_o`: first cycle after reset release.
- Data is issuable the cycle after `imem_rvalid_i`, so first instruction pair out = rvalid edge + 1. The queue does not bypass.
- `single_i` is sampled in cycle t and affects the pair registered at edge t+1.
- Redirect in cycle t: NOP/NOP at t+1; request to the new target at t+1 if nothing is outstanding.
- Full queue: request withheld; no push ever overflows. Empty queue: NOP pairs, no underflow.

## Structure
- Package `fetch_pkg`:
  - `NOP`, `HALT_OP`, `INSTR_W` = 16, opcode field slice.
  - Issue-count type (0/1/2).
- Sub-module `instr_queue`: 2-in/2-out circular FIFO with count, push_n/pop_n inputs, head two words out, flush input. The top level holds the pc, request/stale logic, halt and issue selection.

## Test plan
- Reset release with RESET_PC = 0 and memory words 0x1111..0x8888 at 0..7, 1-cycle rvalid, `single_i` = 0 → pairs (1111,2222), (3333,4444), … in order; no gaps once streaming.
- Same program with `single_i` = 1 on the cycle (1111,2222) is shown → next outputs (3333,0000), then (4444,5555). Every word appears exactly once.
- Redirect to word 5 while a read of 2–3 is outstanding → stale data dropped, NOP/NOP, then (6666,7777) with the 5 word skipped.
- Word 3 = 0xF000 → outputs (1111,2222), (3333? no: 0xF000 at index 3 gives (3333,F000)); `halted_o` = 1; no further `imem_rd_en_o`; subsequent outputs NOP/NOP. A redirect clears `halted_o` and resumes fetch.
- rvalid latency 4 cycles with DEPTH = 4 → the queue never exceeds 4 words, at most one request outstanding, and NOP pairs appear while the queue is empty.
- `rst_n` low mid-stream for 1 cycle → all outputs 0 immediately; refetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, word-count type and opcode helpers for the instruction-pair fetch front end.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;

    localparam logic [INSTR_W-1:0]     NOP     = 16'h0000;
    localparam logic [OP_MSB-OP_LSB:0] HALT_OP = 4'hF;

    // Number of 16-bit words moved into or out of the queue in one cycle.
    typedef enum logic [1:0] {
        CNT_0 = 2'd0,
        CNT_1 = 2'd1,
        CNT_2 = 2'd2
    } word_cnt_t;

    function automatic logic [OP_MSB-OP_LSB:0] opcode(input logic [INSTR_W-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic is_halt(input logic [INSTR_W-1:0] w);
        return opcode(w) == HALT_OP;
    endfunction

endpackage

// File: rtl/instr_pair_fetch_if.sv
// Instruction-memory read bus between the fetch front end (master) and memory (slave).
interface instr_pair_fetch_if #(
    parameter int AW = 8
);
    // rd_en is a one-cycle request qualifying addr; there is no ready. Memory answers
    // one or more cycles later with a one-cycle rvalid qualifying rdata. The master
    // never issues a new request until the previous one has been answered.
    logic          imem_rd_en_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_rdata_i;
    logic          imem_rvalid_i;

    modport master (
        output imem_rd_en_o,
        output imem_addr_o,
        input  imem_rdata_i,
        input  imem_rvalid_i
    );

    modport slave (
        input  imem_rd_en_o,
        input  imem_addr_o,
        output imem_rdata_i,
        output imem_rvalid_i
    );

endinterface

// File: rtl/instr_queue.sv
// Circular word FIFO accepting up to two pushes and two pops per cycle; exposes the two oldest words.
module instr_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  word_cnt_t                  push_n,
    input  logic [INSTR_W-1:0]         push_d0,
    input  logic [INSTR_W-1:0]         push_d1,
    input  word_cnt_t                  pop_n,
    output logic [INSTR_W-1:0]         head0,
    output logic [INSTR_W-1:0]         head1,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr1;
    logic [PW-1:0]      wr_ptr1;
    logic [1:0]         push_v;
    logic [1:0]         pop_v;

    assign push_v  = push_n;
    assign pop_v   = pop_n;
    assign rd_ptr1 = rd_ptr + PW'(1);
    assign wr_ptr1 = wr_ptr + PW'(1);

    // head1 is only meaningful when count >= 2; the caller qualifies it.
    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop_v);
            wr_ptr <= wr_ptr + PW'(push_v);
            count  <= count + CW'(push_v) - CW'(pop_v);
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (!flush && push_n != CNT_0) mem[wr_ptr]  <= push_d0;
        if (!flush && push_n == CNT_2) mem[wr_ptr1] <= push_d1;
    end

endmodule

// File: rtl/instr_pair_fetch.sv
// Dual-issue fetch front end: fetches aligned word pairs, queues them and issues two words per cycle.
module instr_pair_fetch
    import fetch_pkg::*;
#(
    parameter int            AW       = 8,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                single_i,
    input  logic                redirect_valid_i,
    input  logic [AW-1:0]       redirect_pc_i,
    instr_pair_fetch_if.master  imem,
    output logic [INSTR_W-1:0]  instr1_o,
    output logic [INSTR_W-1:0]  instr2_o,
    output logic                halted_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = CW + 1;

    logic [AW-1:0]      pc;
    logic               outstanding;
    logic               stale;
    logic               skip_low;

    logic [CW-1:0]      count;
    logic [INSTR_W-1:0] head0;
    logic [INSTR_W-1:0] head1;
    logic [INSTR_W-1:0] rsp_lo;
    logic [INSTR_W-1:0] rsp_hi;
    logic [INSTR_W-1:0] push_d0;
    logic [INSTR_W-1:0] next1;
    logic [INSTR_W-1:0] next2;
    word_cnt_t          pop_n;
    word_cnt_t          push_n;
    logic [1:0]         pop_v;
    logic               rsp_arrive;
    logic               rsp_take;
    logic               halt_seen;
    logic               room;
    logic               req;

    assign rsp_lo     = imem.imem_rdata_i[INSTR_W-1:0];
    assign rsp_hi     = imem.imem_rdata_i[2*INSTR_W-1:INSTR_W];
    assign rsp_arrive = imem.imem_rvalid_i && outstanding;
    assign rsp_take   = rsp_arrive && !stale && !redirect_valid_i;

    // Issue selection; a redirect discards the queue so nothing is popped.
    always_comb begin
        pop_n = CNT_0;
        next1 = NOP;
        next2 = NOP;
        if (!redirect_valid_i) begin
            if (count >= CW'(2) && !single_i) begin
                pop_n = CNT_2;
                next1 = head0;
                next2 = head1;
            end else if (count != '0) begin
                pop_n = CNT_1;
                next1 = head0;
            end
        end
    end

    // Response unpacking: optional low-word skip, and truncation after a HALT word.
    always_comb begin
        push_n    = CNT_0;
        push_d0   = rsp_lo;
        halt_seen = 1'b0;
        if (rsp_take) begin
            if (skip_low) begin
                push_n    = CNT_1;
                push_d0   = rsp_hi;
                halt_seen = is_halt(rsp_hi);
            end else if (is_halt(rsp_lo)) begin
                push_n    = CNT_1;
                halt_seen = 1'b1;
            end else begin
                push_n    = CNT_2;
                halt_seen = is_halt(rsp_hi);
            end
        end
    end

    // Reserve space for a full pair before requesting so a response can never overflow.
    assign pop_v = pop_n;
    assign room  = (RW'(count) - RW'(pop_v) + RW'(2)) <= RW'(DEPTH);
    assign req   = !outstanding && !halted_o && !redirect_valid_i && room;

    instr_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid_i),
        .push_n  (push_n),
        .push_d0 (push_d0),
        .push_d1 (rsp_hi),
        .pop_n   (pop_n),
        .head0   (head0),
        .head1   (head1),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc                <= RESET_PC;
            outstanding       <= 1'b0;
            stale             <= 1'b0;
            skip_low          <= 1'b0;
            halted_o          <= 1'b0;
            imem.imem_rd_en_o <= 1'b0;
            imem.imem_addr_o  <= '0;
            instr1_o          <= NOP;
            instr2_o          <= NOP;
        end else begin
            instr1_o          <= next1;
            instr2_o          <= next2;
            imem.imem_rd_en_o <= req;
            if (req) begin
                imem.imem_addr_o <= {pc[AW-1:1], 1'b0};
                pc               <= pc + AW'(2);
            end
            // A response in the redirect cycle itself is simply dropped; otherwise mark it stale.
            if (rsp_arrive) begin
                outstanding <= 1'b0;
                stale       <= 1'b0;
            end else if (redirect_valid_i && outstanding) begin
                stale <= 1'b1;
            end
            if (req) outstanding <= 1'b1;
            if (redirect_valid_i) begin
                pc       <= redirect_pc_i;
                skip_low <= redirect_pc_i[0];
                halted_o <= 1'b0;
            end else begin
                if (rsp_take)  skip_low <= 1'b0;
                if (halt_seen) halted_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_pair_fetch.sv
// Bench for instr_pair_fetch: cycle-level word-queue model, reactive memory, directed and random phases.
module tb_instr_pair_fetch;

    localparam int            AW       = 8;
    localparam int            DEPTH    = 4;
    localparam logic [AW-1:0] RESET_PC = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          single = 1'b0;
    logic          redir = 1'b0;
    logic [AW-1:0] redir_pc = '0;
    logic [15:0]   i1;
    logic [15:0]   i2;
    logic          halted;

    instr_pair_fetch_if #(.AW(AW)) imem_bus ();

    instr_pair_fetch #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .single_i         (single),
        .redirect_valid_i (redir),
        .redirect_pc_i    (redir_pc),
        .imem             (imem_bus),
        .instr1_o         (i1),
        .instr2_o         (i2),
        .halted_o         (halted)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // memory environment
    logic [15:0]   mem [256];
    int            lat_min = 1;
    int            lat_max = 1;
    bit            pend = 0;
    int            cd = 0;
    logic [AW-1:0] pa = '0;

    // reference model: words in flight are kept in a plain queue
    logic [15:0]   mq[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_addr;
    logic          m_out, m_stale, m_skip, m_halted, m_rd;
    logic [15:0]   m_i1, m_i2;

    // observation helpers
    bit            rec_en = 0;
    logic [15:0]   seen_q[$];
    logic [15:0]   exp_q[$];
    int            rd_while_halted = 0;
    bit            stream_en = 0;
    bit            seen_any = 0;
    int            nop_pairs = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = RESET_PC; m_addr = '0;
        m_out = 0; m_stale = 0; m_skip = 0; m_halted = 0; m_rd = 0;
        m_i1 = 16'h0; m_i2 = 16'h0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [AW-1:0] t,
                              input logic rv, input logic [31:0] rd);
        logic [15:0] w[$];
        int          take;
        logic        nrd;
        m_i1 = 16'h0; m_i2 = 16'h0; nrd = 0;
        if (r) begin
            mq.delete();
            if (m_out && rv) begin m_out = 0; m_stale = 0; end
            else if (m_out) m_stale = 1;
            m_pc = t; m_skip = t[0]; m_halted = 0;
        end else begin
            take = (mq.size() >= 2 && !s) ? 2 : ((mq.size() >= 1) ? 1 : 0);
            if (take > 0) m_i1 = mq.pop_front();
            if (take > 1) m_i2 = mq.pop_front();
            nrd = !m_out && !m_halted && (mq.size() + 2 <= DEPTH);
            if (m_out && rv) begin
                m_out = 0;
                if (m_stale) m_stale = 0;
                else begin
                    if (!m_skip) w.push_back(rd[15:0]);
                    w.push_back(rd[31:16]);
                    m_skip = 0;
                    foreach (w[k]) begin
                        if (!m_halted) begin
                            mq.push_back(w[k]);
                            if (w[k][15:12] == 4'hF) m_halted = 1;
                        end
                    end
                end
            end
            if (nrd) begin
                m_addr = {m_pc[AW-1:1], 1'b0};
                m_pc   = m_pc + AW'(2);
                m_out  = 1;
            end
        end
        m_rd = nrd;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic s, input logic r, input logic [AW-1:0] t);
        logic        rv;
        logic [31:0] rd;
        check("instr1_o", i1, m_i1);
        check("instr2_o", i2, m_i2);
        check("halted_o", halted, m_halted);
        check("imem_rd_en_o", imem_bus.imem_rd_en_o, m_rd);
        check("imem_addr_o", imem_bus.imem_addr_o, m_addr);
        if (rec_en) begin
            if (i1 != 16'h0) seen_q.push_back(i1);
            if (i2 != 16'h0) seen_q.push_back(i2);
        end
        if (stream_en) begin
            if (seen_any && i1 == 16'h0 && i2 == 16'h0) nop_pairs++;
            if (i1 != 16'h0) seen_any = 1;
        end
        if (halted && imem_bus.imem_rd_en_o) rd_while_halted++;
        if (imem_bus.imem_rd_en_o) check("one_outstanding", pend, 1'b0);
        rv = 0;
        rd = $urandom;
        if (pend && cd == 0) begin
            rv = 1; rd = {mem[pa + AW'(1)], mem[pa]}; pend = 0;
        end else if (pend) begin
            cd--;
        end
        if (imem_bus.imem_rd_en_o) begin
            pend = 1;
            cd   = $urandom_range(lat_max, lat_min) - 1;
            pa   = imem_bus.imem_addr_o;
        end
        single = s; redir = r; redir_pc = t;
        imem_bus.imem_rvalid_i = rv;
        imem_bus.imem_rdata_i  = rd;
        model_step(s, r, t, rv, rd);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 0; single = 0; redir = 0; redir_pc = '0;
        imem_bus.imem_rvalid_i = 0; imem_bus.imem_rdata_i = '0;
        pend = 0;
        model_reset();
        @(negedge clk);
        check("reset_instr", {i1, i2}, 32'h0);
        check("reset_rd_en", imem_bus.imem_rd_en_o, 1'b0);
        check("reset_addr", imem_bus.imem_addr_o, 32'h0);
        check("reset_halted", halted, 1'b0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic fill_mem(input bit seq, input bit allow_halt);
        for (int a = 0; a < 256; a++) begin
            logic [3:0] op;
            op = allow_halt ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 14));
            mem[a] = {op, 12'($urandom)};
        end
        if (seq) for (int a = 0; a < 8; a++) mem[a] = 16'h1111 * 16'(a + 1);
    endtask

    // Compare the first exp_q.size() recorded words against exp_q.
    task automatic check_words(input string name);
        for (int k = 0; k < exp_q.size(); k++) begin
            check(name, (k < seen_q.size()) ? {16'h0, seen_q[k]} : 32'hFFFF_FFFF, {16'h0, exp_q[k]});
        end
    endtask

    task automatic load_seq_exp(input int first, input int n);
        exp_q.delete();
        for (int k = first; k < first + n; k++) exp_q.push_back(16'h1111 * 16'(k + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        bit found;

        // A: sequential program, dual issue throughout
        fill_mem(1, 0);
        lat_min = 1; lat_max = 1;
        apply_reset();
        seen_q.delete(); rec_en = 1;
        repeat (40) cycle(0, 0, '0);
        load_seq_exp(0, 8);
        check_words("stream_dual");

        // B: random single-issue; every word appears once, in order
        apply_reset();
        seen_q.delete();
        repeat (60) cycle(1'($urandom_range(0, 1)), 0, '0);
        check_words("stream_single");

        // C: redirect to an odd target while the 2-3 pair is in flight
        lat_min = 3; lat_max = 3;
        apply_reset();
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (imem_bus.imem_rd_en_o && imem_bus.imem_addr_o == AW'(2)) found = 1;
            else cycle(0, 0, '0);
        end
        check("wait_req_addr2", found, 1'b1);
        cycle(0, 1, AW'(5));
        seen_q.delete();
        check("redirect_nop", {i1, i2}, 32'h0);
        repeat (40) cycle(0, 0, '0);
        load_seq_exp(5, 3);
        check_words("redirect_words");

        // D: HALT in word 3, then resume by redirect
        fill_mem(1, 0);
        mem[3] = 16'hF000;
        lat_min = 1; lat_max = 1;
        apply_reset();
        seen_q.delete(); rd_while_halted = 0;
        repeat (30) cycle(0, 0, '0);
        exp_q.delete();
        exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
        exp_q.push_back(16'h3333); exp_q.push_back(16'hF000);
        check_words("halt_words");
        check("halt_word_count", seen_q.size(), 4);
        check("halt_flag", halted, 1'b1);
        check("rd_while_halted", rd_while_halted, 0);
        cycle(0, 1, '0);
        check("halt_cleared", halted, 1'b0);
        found = 0;
        for (int k = 0; k < 5 && !found; k++) begin
            if (imem_bus.imem_rd_en_o && imem_bus.imem_addr_o == AW'(0)) found = 1;
            else cycle(0, 0, '0);
        end
        check("resume_fetch", found, 1'b1);
        rec_en = 0;

        // E: long memory latency, NOP pairs while the queue runs dry
        fill_mem(1, 0);
        lat_min = 4; lat_max = 4;
        apply_reset();
        seen_q.delete(); rec_en = 1; stream_en = 1; seen_any = 0; nop_pairs = 0;
        repeat (60) cycle(1'($urandom_range(0, 1)), 0, '0);
        check("nop_while_empty", nop_pairs > 0, 1'b1);
        load_seq_exp(0, 8);
        check_words("stream_slow");
        stream_en = 0; rec_en = 0;

        // F: asynchronous reset mid-stream, then refetch from RESET_PC
        lat_min = 1; lat_max = 2;
        repeat (7) cycle(0, 0, '0);
        #2 rst_n = 0;
        #1;
        check("async_reset_outputs", {i1, i2}, 32'h0);
        check("async_reset_ctrl", {halted, imem_bus.imem_rd_en_o, imem_bus.imem_addr_o}, 32'h0);
        @(negedge clk);
        pend = 0; single = 0; redir = 0;
        imem_bus.imem_rvalid_i = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        found = 0;
        for (int k = 0; k < 5 && !found; k++) begin
            if (imem_bus.imem_rd_en_o) found = 1;
            else cycle(0, 0, '0);
        end
        check("refetch_req", found, 1'b1);
        check("refetch_addr", imem_bus.imem_addr_o, RESET_PC);

        // G: random program with halts, redirects, single issue and latency
        fill_mem(0, 1);
        lat_min = 1; lat_max = 4;
        apply_reset();
        for (int n = 0; n < 2000; n++) begin
            logic r;
            r = ($urandom_range(0, 99) < 6);
            cycle(1'($urandom_range(0, 1)), r, AW'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
